// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: holds in-flight predictions, checks them
// against execute outcomes, raises flush/redirect on a mispredict and queues
// BHT/BTB write-backs toward the table controller.
module branch_resolve_ctrl #(
  parameter int PC_W      = 11,
  parameter int DEPTH     = 4,
  parameter int UPD_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_valid,
  output logic            pred_ready,
  input  logic [PC_W-1:0] pred_pc,
  input  logic            pred_hit,
  input  logic [PC_W-1:0] pred_target,
  input  logic            res_valid,
  output logic            res_ready,
  input  logic            res_is_branch,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc,
  output logic            upd_valid,
  input  logic            upd_ready,
  output logic [PC_W-1:0] pc_fetch_update,
  output logic [PC_W-1:0] pc_target_update,
  output logic            upd_invalidate,
  output logic [15:0]     br_count,
  output logic [15:0]     mp_count,
  output logic            err
);

  localparam int QA = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int UA = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
  localparam logic [QA:0]   Q_FULL = (QA+1)'(DEPTH);
  localparam logic [UA:0]   U_FULL = (UA+1)'(UPD_DEPTH);
  localparam logic [QA-1:0] QP_ONE = QA'(1);
  localparam logic [QA:0]   QC_ONE = (QA+1)'(1);
  localparam logic [UA-1:0] UP_ONE = UA'(1);
  localparam logic [UA:0]   UC_ONE = (UA+1)'(1);

  // Saturating event counter increment
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Sequential fall-through PC, wrapping modulo 2^PC_W
  function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

  // Prediction queue storage
  logic [PC_W-1:0] q_pc  [DEPTH];
  logic            q_hit [DEPTH];
  logic [PC_W-1:0] q_tgt [DEPTH];
  logic [QA-1:0]   q_rd, q_wr;
  logic [QA:0]     q_cnt;

  // Update buffer storage
  logic [PC_W-1:0] u_pc  [UPD_DEPTH];
  logic [PC_W-1:0] u_tgt [UPD_DEPTH];
  logic            u_inv [UPD_DEPTH];
  logic [UA-1:0]   u_rd, u_wr;
  logic [UA:0]     u_cnt;

  logic            pred_acc, res_acc, resolve, err_hit;
  logic            act_taken, mp_raw, mispred, upd_pop;
  logic [PC_W-1:0] h_pc, h_tgt;
  logic            h_hit;

  assign pred_ready = (q_cnt != Q_FULL);
  assign upd_valid  = (u_cnt != '0);
  assign upd_pop    = upd_valid & upd_ready;
  assign res_ready  = (u_cnt != U_FULL) | upd_pop;
  assign pred_acc   = pred_valid & pred_ready;
  assign res_acc    = res_valid & res_ready;
  assign resolve    = res_acc & (q_cnt != '0);
  assign err_hit    = res_acc & (q_cnt == '0);
  assign act_taken  = res_is_branch & res_taken;

  assign h_pc  = q_pc[q_rd];
  assign h_hit = q_hit[q_rd];
  assign h_tgt = q_tgt[q_rd];

  // Direction/target check of the head prediction against the outcome
  always_comb begin
    mp_raw = h_hit;
    if (act_taken) mp_raw = !h_hit || (h_tgt != res_target);
  end

  assign mispred = resolve & mp_raw;

  assign pc_fetch_update  = upd_valid ? u_pc[u_rd]  : '0;
  assign pc_target_update = upd_valid ? u_tgt[u_rd] : '0;
  assign upd_invalidate   = upd_valid ? u_inv[u_rd] : 1'b0;

  // Control state: queue pointers, flush/redirect, counters, error flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_rd        <= '0;
      q_wr        <= '0;
      q_cnt       <= '0;
      u_rd        <= '0;
      u_wr        <= '0;
      u_cnt       <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      br_count    <= '0;
      mp_count    <= '0;
      err         <= 1'b0;
    end else begin
      flush <= mispred;
      if (mispred) redirect_pc <= act_taken ? res_target : next_pc(h_pc);

      // A mispredict discards every younger entry and any same-cycle push
      if (mispred) begin
        q_rd  <= '0;
        q_wr  <= '0;
        q_cnt <= '0;
      end else begin
        if (pred_acc) q_wr <= q_wr + QP_ONE;
        if (resolve)  q_rd <= q_rd + QP_ONE;
        case ({pred_acc, resolve})
          2'b10:   q_cnt <= q_cnt + QC_ONE;
          2'b01:   q_cnt <= q_cnt - QC_ONE;
          default: q_cnt <= q_cnt;
        endcase
      end

      if (mispred) u_wr <= u_wr + UP_ONE;
      if (upd_pop) u_rd <= u_rd + UP_ONE;
      case ({mispred, upd_pop})
        2'b10:   u_cnt <= u_cnt + UC_ONE;
        2'b01:   u_cnt <= u_cnt - UC_ONE;
        default: u_cnt <= u_cnt;
      endcase

      if (resolve && res_is_branch) br_count <= sat_inc(br_count);
      if (mispred)                  mp_count <= sat_inc(mp_count);
      if (err_hit)                  err      <= 1'b1;
    end
  end

  // Payload writes; occupancy is tracked by the control block alone
  always_ff @(posedge clk) begin
    if (pred_acc) begin
      q_pc[q_wr]  <= pred_pc;
      q_hit[q_wr] <= pred_hit;
      q_tgt[q_wr] <= pred_target;
    end
    if (mispred) begin
      u_pc[u_wr]  <= h_pc;
      u_tgt[u_wr] <= act_taken ? res_target : '0;
      u_inv[u_wr] <= !act_taken;
    end
  end

endmodule
